// File: rtl/if_stage_buf.sv
// if_stage_buf: instruction-fetch stage with a small output FIFO.
//   Owns the fetch PC and issues reads to an instruction SRAM with a fixed
//   1-cycle read latency. Each returned word is paired with its PC and queued.
//   The queue head goes to decode over a valid/allowin handshake. A redirect
//   (br_valid) flushes everything that is queued or in flight.
// Ports:
//   clk, resetn                  clock, async active-low reset
//   inst_sram_en/wen/addr/wdata  SRAM request (read-only use, wen/wdata tied 0)
//   inst_sram_rdata              data for the request of the previous cycle
//   br_valid, br_target          redirect pulse and target (low 2 bits ignored)
//   ds_allowin                   decode accepts the head this cycle
//   fs_to_ds_valid/pc/inst       FIFO head toward decode
module if_stage_buf #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_en,
  output logic        inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_to_ds_pc,
  output logic [31:0] fs_to_ds_inst
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fs_entry_t;

  fs_entry_t       mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            inflight;
  logic [31:0]     rsp_pc;
  logic [31:0]     fetch_pc;

  logic            pop, push, issue;
  logic [CW:0]     occ;
  logic            br_unused;

  assign br_unused = ^br_target[1:0];

  assign fs_to_ds_valid = (count != '0);
  // Masked when empty so stale storage never shows on the outputs.
  assign fs_to_ds_pc    = fs_to_ds_valid ? mem[rd_ptr].pc   : '0;
  assign fs_to_ds_inst  = fs_to_ds_valid ? mem[rd_ptr].inst : '0;

  assign pop  = fs_to_ds_valid & ds_allowin & ~br_valid;
  // A response landing in a redirect cycle is dropped with the flush.
  assign push = inflight & ~br_valid;

  // Credit check: stored + outstanding after this cycle's pop must leave a
  // free slot, so a returning word always has somewhere to go.
  assign occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue = resetn & ~br_valid & (occ < (CW+1)'(DEPTH));

  assign inst_sram_en    = issue;
  assign inst_sram_wen   = 1'b0;
  assign inst_sram_addr  = fetch_pc;
  assign inst_sram_wdata = '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= '0;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (br_valid) begin
      fetch_pc <= {br_target[31:2], 2'b00};
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
        rsp_pc   <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: reads are masked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: rsp_pc, inst: inst_sram_rdata};
  end

endmodule

// File: tb/tb_if_stage_buf.sv
// Directed bench for if_stage_buf: SRAM model returns a scrambled address one
// cycle after each enabled request; a monitor records every handshake.
module tb_if_stage_buf;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_en, inst_sram_wen;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic        br_valid;
  logic [31:0] br_target;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [31:0] fs_to_ds_pc, fs_to_ds_inst;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];

  always #5 clk = ~clk;

  if_stage_buf #(.DEPTH(4), .RESET_PC(32'h1c000000)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .br_valid(br_valid), .br_target(br_target), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_pc(fs_to_ds_pc),
    .fs_to_ds_inst(fs_to_ds_inst)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'h5a5a5a5a;
  endfunction

  // SRAM: 1-cycle latency; garbage when not enabled.
  always @(posedge clk)
    inst_sram_rdata <= inst_sram_en ? memw(inst_sram_addr) : 32'hdeadbeef;

  always @(posedge clk)
    if (resetn && fs_to_ds_valid && ds_allowin && !br_valid) begin
      q_pc.push_back(fs_to_ds_pc);
      q_inst.push_back(fs_to_ds_inst);
    end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic chk_seq(input string tag, input logic [31:0] start, input int n);
    chk({tag, "_cnt"}, 32'(q_pc.size()), 32'(n));
    for (int i = 0; i < n && i < q_pc.size(); i++) begin
      logic [31:0] epc;
      epc = start + 32'(4 * i);
      chk($sformatf("%s_pc%0d", tag, i), q_pc[i], epc);
      chk($sformatf("%s_in%0d", tag, i), q_inst[i], memw(epc));
    end
  endtask

  task automatic qclear();
    q_pc.delete();
    q_inst.delete();
  endtask

  task automatic step(input logic br, input logic [31:0] tgt, input logic al);
    @(negedge clk);
    br_valid = br; br_target = tgt; ds_allowin = al;
    #1;
  endtask

  // One-cycle reset pulse, then release; returns inside cycle C0.
  task automatic restart(input logic al);
    @(negedge clk);
    resetn = 1'b0; br_valid = 1'b0; ds_allowin = al;
    @(negedge clk);
    resetn = 1'b1;
    qclear();
    #1;
  endtask

  initial begin
    resetn = 1'b0; br_valid = 1'b0; br_target = '0; ds_allowin = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_en",   32'(inst_sram_en),   32'd0);
    chk("rst_vld",  32'(fs_to_ds_valid), 32'd0);
    chk("rst_pc",   fs_to_ds_pc,         32'd0);
    chk("rst_inst", fs_to_ds_inst,       32'd0);

    // Streaming after reset
    @(negedge clk); resetn = 1'b1; qclear(); #1;
    chk("s_en0",  32'(inst_sram_en),   32'd1);
    chk("s_a0",   inst_sram_addr,      32'h1c000000);
    chk("s_v0",   32'(fs_to_ds_valid), 32'd0);
    chk("s_wen",  32'(inst_sram_wen),  32'd0);
    chk("s_wd",   inst_sram_wdata,     32'd0);
    step(0, 0, 1);
    chk("s_a1",   inst_sram_addr,      32'h1c000004);
    chk("s_v1",   32'(fs_to_ds_valid), 32'd0);
    step(0, 0, 1);
    chk("s_a2",   inst_sram_addr,      32'h1c000008);
    chk("s_v2",   32'(fs_to_ds_valid), 32'd1);
    chk("s_pc2",  fs_to_ds_pc,         32'h1c000000);
    chk("s_in2",  fs_to_ds_inst,       memw(32'h1c000000));
    repeat (5) step(0, 0, 1);
    chk_seq("s_seq", 32'h1c000000, 5);

    // Backpressure: four credits, then stall with a stable head
    restart(0);
    chk("bp_a0", inst_sram_addr, 32'h1c000000);
    for (int c = 1; c <= 3; c++) begin
      step(0, 0, 0);
      chk($sformatf("bp_en%0d", c), 32'(inst_sram_en), 32'd1);
      chk($sformatf("bp_a%0d", c),  inst_sram_addr, 32'h1c000000 + 32'(4 * c));
    end
    for (int c = 4; c <= 7; c++) begin
      step(0, 0, 0);
      chk($sformatf("bp_en%0d", c), 32'(inst_sram_en), 32'd0);
      chk($sformatf("bp_pc%0d", c), fs_to_ds_pc, 32'h1c000000);
    end
    chk("bp_inst", fs_to_ds_inst, memw(32'h1c000000));
    chk("bp_nopop", 32'(q_pc.size()), 32'd0);
    step(0, 0, 1);
    chk("bp_res_en", 32'(inst_sram_en), 32'd1);
    chk("bp_res_a",  inst_sram_addr,    32'h1c000010);
    repeat (7) step(0, 0, 1);
    chk_seq("bp_seq", 32'h1c000000, 7);

    // Redirect with 3 stored + 1 in flight
    restart(0);
    repeat (3) step(0, 0, 0);
    step(1, 32'h1c000103, 0);
    chk("br_en", 32'(inst_sram_en), 32'd0);
    step(0, 0, 1);
    chk("br_v1", 32'(fs_to_ds_valid), 32'd0);
    chk("br_e1", 32'(inst_sram_en),   32'd1);
    chk("br_a1", inst_sram_addr,      32'h1c000100);
    step(0, 0, 1);
    chk("br_v2", 32'(fs_to_ds_valid), 32'd0);
    chk("br_a2", inst_sram_addr,      32'h1c000104);
    step(0, 0, 1);
    chk("br_v3",  32'(fs_to_ds_valid), 32'd1);
    chk("br_pc3", fs_to_ds_pc,         32'h1c000100);
    repeat (3) step(0, 0, 1);
    chk_seq("br_seq", 32'h1c000100, 3);

    // Redirect while a valid head is being accepted; target wraps
    step(1, 32'hfffffff8, 1);
    qclear();
    chk("wr_hv", 32'(fs_to_ds_valid), 32'd1);
    chk("wr_en", 32'(inst_sram_en),   32'd0);
    step(0, 0, 1);
    chk("wr_v1", 32'(fs_to_ds_valid), 32'd0);
    chk("wr_a1", inst_sram_addr,      32'hfffffff8);
    step(0, 0, 1);
    chk("wr_a2", inst_sram_addr,      32'hfffffffc);
    step(0, 0, 1);
    chk("wr_a3", inst_sram_addr,      32'h00000000);
    chk("wr_pc3", fs_to_ds_pc,        32'hfffffff8);
    repeat (3) step(0, 0, 1);
    chk_seq("wr_seq", 32'hfffffff8, 3);

    // Asynchronous reset with entries queued
    restart(0);
    repeat (4) step(0, 0, 0);
    chk("ar_pre", 32'(fs_to_ds_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("ar_en",   32'(inst_sram_en),   32'd0);
    chk("ar_vld",  32'(fs_to_ds_valid), 32'd0);
    chk("ar_pc",   fs_to_ds_pc,         32'd0);
    chk("ar_inst", fs_to_ds_inst,       32'd0);
    @(negedge clk);
    resetn = 1'b1; ds_allowin = 1'b1; qclear();
    #1;
    chk("ar_a0", inst_sram_addr,      32'h1c000000);
    chk("ar_v0", 32'(fs_to_ds_valid), 32'd0);
    repeat (5) step(0, 0, 1);
    chk_seq("ar_seq", 32'h1c000000, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
